// File: rtl/sb_gpio_irq_if.sv
// c101 system-bus (sb) slave bundle: independent read and write channels,
// each with a request handshake and a response handshake.
interface sb_gpio_irq_if;
    logic        sb_arvalid;
    logic        sb_arready;
    logic [31:0] sb_araddr;
    logic        sb_rvalid;
    logic        sb_rready;
    logic [31:0] sb_rdata;
    logic        sb_wvalid;
    logic        sb_wready;
    logic [31:0] sb_waddr;
    logic [31:0] sb_wdata;
    logic [3:0]  sb_wstrb;
    logic        sb_bvalid;
    logic        sb_bready;
    logic        sb_bresp;

    modport master (
        output sb_arvalid, sb_araddr, sb_rready,
        output sb_wvalid, sb_waddr, sb_wdata, sb_wstrb, sb_bready,
        input  sb_arready, sb_rvalid, sb_rdata,
        input  sb_wready, sb_bvalid, sb_bresp
    );

    modport slave (
        input  sb_arvalid, sb_araddr, sb_rready,
        input  sb_wvalid, sb_waddr, sb_wdata, sb_wstrb, sb_bready,
        output sb_arready, sb_rvalid, sb_rdata,
        output sb_wready, sb_bvalid, sb_bresp
    );
endinterface

// File: rtl/sb_gpio_irq.sv
// GPIO slave for the sb bus: per-pin direction, atomic set/clear of outputs,
// synchronized inputs and rising/falling edge interrupts with W1C status.
module sb_gpio_irq #(
    parameter int GPIO_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sb_clk,
    input  logic              sb_rst,
    sb_gpio_irq_if.slave      bus,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              irq
);

    typedef enum logic { R_IDLE, R_RESP } r_state_t;
    typedef enum logic { W_IDLE, W_RESP } w_state_t;

    localparam logic [2:0] IDX_IN     = 3'd0;
    localparam logic [2:0] IDX_OUT    = 3'd1;
    localparam logic [2:0] IDX_DIR    = 3'd2;
    localparam logic [2:0] IDX_SET    = 3'd3;
    localparam logic [2:0] IDX_CLR    = 3'd4;
    localparam logic [2:0] IDX_RISE   = 3'd5;
    localparam logic [2:0] IDX_FALL   = 3'd6;
    localparam logic [2:0] IDX_STATUS = 3'd7;

    r_state_t          r_state;
    w_state_t          w_state;
    logic              arready_q, rvalid_q, wready_q, bvalid_q, bresp_q;
    logic [31:0]       rdata_q;

    logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_W-1:0] sync_in, prev_in;
    logic [GPIO_W-1:0] out_q, dir_q, rise_en_q, fall_en_q, status_q;
    logic [GPIO_W-1:0] out_next, dir_next, rise_en_next, fall_en_next, status_next;
    logic [GPIO_W-1:0] rise, fall, w1c_mask;

    logic              ar_fire, w_fire, r_mapped, w_mapped;
    logic [2:0]        r_idx, w_idx;
    logic [31:0]       lane_mask32;
    logic [GPIO_W-1:0] lane_mask, wbits, rd_val;
    logic [31:0]       rd_word;
    logic              unused_bits;

    assign ar_fire  = arready_q & bus.sb_arvalid;
    assign w_fire   = wready_q & bus.sb_wvalid;
    assign r_mapped = (bus.sb_araddr[7:5] == 3'b000);
    assign w_mapped = (bus.sb_waddr[7:5] == 3'b000);
    assign r_idx    = bus.sb_araddr[4:2];
    assign w_idx    = bus.sb_waddr[4:2];

    assign lane_mask32 = {{8{bus.sb_wstrb[3]}}, {8{bus.sb_wstrb[2]}},
                          {8{bus.sb_wstrb[1]}}, {8{bus.sb_wstrb[0]}}};
    assign lane_mask   = lane_mask32[GPIO_W-1:0];
    assign wbits       = bus.sb_wdata[GPIO_W-1:0] & lane_mask;

    // Address bits outside [7:2] and data lanes above GPIO_W are don't-care.
    assign unused_bits = ^{bus.sb_araddr[31:8], bus.sb_araddr[1:0],
                           bus.sb_waddr[31:8], bus.sb_waddr[1:0],
                           bus.sb_wdata, lane_mask32};

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign rise    = sync_in & ~prev_in & rise_en_q;
    assign fall    = ~sync_in & prev_in & fall_en_q;

    always_ff @(posedge sb_clk or posedge sb_rst) begin
        if (sb_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_in <= '0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_in <= sync_in;
        end
    end

    always_comb begin
        out_next     = out_q;
        dir_next     = dir_q;
        rise_en_next = rise_en_q;
        fall_en_next = fall_en_q;
        w1c_mask     = '0;
        if (w_fire && w_mapped) begin
            case (w_idx)
                IDX_OUT:    out_next     = (out_q & ~lane_mask) | wbits;
                IDX_DIR:    dir_next     = (dir_q & ~lane_mask) | wbits;
                IDX_SET:    out_next     = out_q | wbits;
                IDX_CLR:    out_next     = out_q & ~wbits;
                IDX_RISE:   rise_en_next = (rise_en_q & ~lane_mask) | wbits;
                IDX_FALL:   fall_en_next = (fall_en_q & ~lane_mask) | wbits;
                IDX_STATUS: w1c_mask     = wbits;
                default:    ;
            endcase
        end
        // New events are ORed in after the clear, so a same-cycle set wins.
        status_next = (status_q & ~w1c_mask) | rise | fall;
    end

    always_ff @(posedge sb_clk or posedge sb_rst) begin
        if (sb_rst) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
        end else begin
            out_q     <= out_next;
            dir_q     <= dir_next;
            rise_en_q <= rise_en_next;
            fall_en_q <= fall_en_next;
            status_q  <= status_next;
        end
    end

    always_comb begin
        rd_word = '0;
        case (r_idx)
            IDX_IN:     rd_val = sync_in;
            IDX_OUT:    rd_val = out_q;
            IDX_DIR:    rd_val = dir_q;
            IDX_RISE:   rd_val = rise_en_q;
            IDX_FALL:   rd_val = fall_en_q;
            IDX_STATUS: rd_val = status_q;
            default:    rd_val = '0;
        endcase
        if (r_mapped) rd_word[GPIO_W-1:0] = rd_val;
    end

    // Read data is captured from pre-write register values at the ar edge.
    always_ff @(posedge sb_clk or posedge sb_rst) begin
        if (sb_rst) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (ar_fire) begin
                    r_state   <= R_RESP;
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b1;
                    rdata_q   <= rd_word;
                end
                R_RESP: if (bus.sb_rready) begin
                    r_state   <= R_IDLE;
                    arready_q <= 1'b1;
                    rvalid_q  <= 1'b0;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge sb_clk or posedge sb_rst) begin
        if (sb_rst) begin
            w_state  <= W_IDLE;
            wready_q <= 1'b1;
            bvalid_q <= 1'b0;
            bresp_q  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (w_fire) begin
                    w_state  <= W_RESP;
                    wready_q <= 1'b0;
                    bvalid_q <= 1'b1;
                    bresp_q  <= ~w_mapped;
                end
                W_RESP: if (bus.sb_bready) begin
                    w_state  <= W_IDLE;
                    wready_q <= 1'b1;
                    bvalid_q <= 1'b0;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign bus.sb_arready = arready_q;
    assign bus.sb_rvalid  = rvalid_q;
    assign bus.sb_rdata   = rdata_q;
    assign bus.sb_wready  = wready_q;
    assign bus.sb_bvalid  = bvalid_q;
    assign bus.sb_bresp   = bresp_q;

    assign gpio_o  = out_q;
    assign gpio_oe = dir_q;
    assign irq     = |status_q;

endmodule

// File: tb/tb_sb_gpio_irq.sv
// Scoreboarded bench for sb_gpio_irq: a register-map model predicts every read
// and write response, a negedge monitor pops and compares them.
module tb_sb_gpio_irq;
    localparam int W  = 16;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] gpio_i, gpio_o, gpio_oe;
    logic         irq;

    sb_gpio_irq_if bus ();

    sb_gpio_irq #(.GPIO_W(W), .SYNC_STAGES(SS)) dut (
        .sb_clk(clk), .sb_rst(rst), .bus(bus),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_expect [$];
    logic        wr_expect [$];

    logic [W-1:0] m_in, m_out, m_dir, m_rise, m_fall, m_status;
    logic         irq_at_accept;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [W-1:0] lanes(input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return m[W-1:0];
    endfunction

    function automatic void model_reset();
        m_in = '0; m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_status = '0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        case (a[7:2])
            6'd0: r[W-1:0] = m_in;
            6'd1: r[W-1:0] = m_out;
            6'd2: r[W-1:0] = m_dir;
            6'd5: r[W-1:0] = m_rise;
            6'd6: r[W-1:0] = m_fall;
            6'd7: r[W-1:0] = m_status;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic model_bresp(input logic [31:0] a);
        return (a[7:0] >= 8'h20);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [W-1:0] m, v;
        m = lanes(s);
        v = d[W-1:0] & m;
        if (a[7:0] < 8'h20) begin
            case (a[4:2])
                3'd1: m_out    = (m_out & ~m) | v;
                3'd2: m_dir    = (m_dir & ~m) | v;
                3'd3: m_out    = m_out | v;
                3'd4: m_out    = m_out & ~v;
                3'd5: m_rise   = (m_rise & ~m) | v;
                3'd6: m_fall   = (m_fall & ~m) | v;
                3'd7: m_status = m_status & ~v;
                default: ;
            endcase
        end
    endfunction

    // Settled pin change: edge events latch into STATUS, IN follows the pins.
    function automatic void model_pins(input logic [W-1:0] nv);
        m_status = m_status | (nv & ~m_in & m_rise) | (~nv & m_in & m_fall);
        m_in     = nv;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.sb_rvalid && bus.sb_rready) begin
                if (rd_expect.size() == 0) fail_now("unexpected_rvalid");
                else checkOutput("rdata", bus.sb_rdata, rd_expect.pop_front());
            end
            if (bus.sb_bvalid && bus.sb_bready) begin
                if (wr_expect.size() == 0) fail_now("unexpected_bvalid");
                else checkOutput("bresp", {31'd0, bus.sb_bresp}, {31'd0, wr_expect.pop_front()});
            end
        end
    end

    task automatic do_read(input logic [31:0] a, input bit wait_done);
        int n;
        bus.sb_araddr  = a;
        bus.sb_arvalid = 1'b1;
        n = 0;
        while (!bus.sb_arready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.sb_arready) fail_now("ar_timeout");
        rd_expect.push_back(model_read(a));
        @(posedge clk); #1;
        bus.sb_arvalid = 1'b0;
        if (wait_done) begin
            n = 0;
            while (bus.sb_rvalid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (bus.sb_rvalid) fail_now("r_timeout");
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input bit wait_done);
        int n;
        bus.sb_waddr  = a;
        bus.sb_wdata  = d;
        bus.sb_wstrb  = s;
        bus.sb_wvalid = 1'b1;
        n = 0;
        while (!bus.sb_wready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.sb_wready) fail_now("w_timeout");
        wr_expect.push_back(model_bresp(a));
        @(posedge clk); #1;
        bus.sb_wvalid = 1'b0;
        irq_at_accept = irq;
        model_write(a, d, s);
        if (wait_done) begin
            n = 0;
            while (bus.sb_bvalid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (bus.sb_bvalid) fail_now("b_timeout");
        end
    endtask

    task automatic set_pins(input logic [W-1:0] v);
        gpio_i = v;
        repeat (SS + 2) @(posedge clk);
        #1;
        model_pins(v);
    endtask

    task automatic applyStimulus(input int count);
        logic [31:0] a, d;
        for (int i = 0; i < count; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    a = {24'd0, 3'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
                    d = $urandom;
                    do_write(a, d, 4'($urandom_range(0, 15)), 1);
                    checkOutput("rand_gpio_o", {16'd0, gpio_o}, {16'd0, m_out});
                    checkOutput("rand_gpio_oe", {16'd0, gpio_oe}, {16'd0, m_dir});
                    checkOutput("rand_irq", {31'd0, irq}, {31'd0, |m_status});
                end
                1: do_write(32'($urandom_range(32, 255)), $urandom, 4'hF, 1);
                2: do_read(32'($urandom_range(0, 255)), 1);
                default: set_pins(W'($urandom));
            endcase
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        gpio_i = '0;
        bus.sb_arvalid = 0; bus.sb_araddr = '0; bus.sb_rready = 1;
        bus.sb_wvalid = 0; bus.sb_waddr = '0; bus.sb_wdata = '0; bus.sb_wstrb = '0; bus.sb_bready = 1;
        model_reset();
        irq_at_accept = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_arready", {31'd0, bus.sb_arready}, 32'd1);
        checkOutput("rst_wready", {31'd0, bus.sb_wready}, 32'd1);
        checkOutput("rst_rvalid", {31'd0, bus.sb_rvalid}, 32'd0);
        checkOutput("rst_bvalid", {31'd0, bus.sb_bvalid}, 32'd0);
        checkOutput("rst_rdata", bus.sb_rdata, 32'd0);
        checkOutput("rst_bresp", {31'd0, bus.sb_bresp}, 32'd0);
        checkOutput("rst_gpio_o", {16'd0, gpio_o}, 32'd0);
        checkOutput("rst_gpio_oe", {16'd0, gpio_oe}, 32'd0);
        checkOutput("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_read(32'h04, 1);
        do_read(32'h08, 1);
        do_read(32'h40, 1);
        do_write(32'h40, 32'hFFFF_FFFF, 4'hF, 1);
        do_read(32'h04, 1);

        do_write(32'h08, 32'h0000_00FF, 4'hF, 1);
        do_write(32'h04, 32'h0000_1234, 4'hF, 1);
        do_write(32'h0C, 32'h0000_8001, 4'hF, 1);
        do_write(32'h10, 32'h0000_0004, 4'hF, 1);
        checkOutput("gpio_o_setclr", {16'd0, gpio_o}, 32'h0000_9231);
        checkOutput("gpio_oe_dir", {16'd0, gpio_oe}, 32'h0000_00FF);
        do_write(32'h04, 32'h0000_ABCD, 4'b0010, 1);
        checkOutput("gpio_o_strobe", {16'd0, gpio_o}, 32'h0000_AB31);
        do_read(32'h04, 1);
        do_read(32'h0C, 1);

        do_write(32'h14, 32'h1, 4'hF, 1);
        gpio_i[0] = 1'b1;
        @(posedge clk); #1;
        checkOutput("irq_capture", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        checkOutput("irq_early", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        checkOutput("irq_on_time", {31'd0, irq}, 32'd1);
        model_pins(gpio_i);
        do_read(32'h1C, 1);
        set_pins(gpio_i & ~W'(1));
        do_read(32'h1C, 1);

        gpio_i[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_write(32'h1C, 32'h1, 4'hF, 1);
        model_pins(gpio_i);
        do_read(32'h1C, 1);
        do_write(32'h1C, 32'h1, 4'hF, 1);
        checkOutput("irq_w1c_clear", {31'd0, irq_at_accept}, 32'd0);
        do_read(32'h1C, 1);

        fork
            do_read(32'h04, 1);
            do_write(32'h04, 32'h0000_5A5A, 4'hF, 1);
        join
        do_read(32'h04, 1);

        bus.sb_rready = 1'b0;
        do_read(32'h04, 0);
        do_write(32'h18, 32'h0000_00F0, 4'hF, 1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_rvalid", {31'd0, bus.sb_rvalid}, 32'd1);
            checkOutput("bp_arready", {31'd0, bus.sb_arready}, 32'd0);
            checkOutput("bp_rdata", bus.sb_rdata, {16'd0, 16'h5A5A});
            @(posedge clk); #1;
        end
        bus.sb_rready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        applyStimulus(60);

        bus.sb_rready = 1'b0;
        bus.sb_bready = 1'b0;
        gpio_i = '0;
        do_read(32'h08, 0);
        do_write(32'h14, 32'h0000_FFFF, 4'hF, 0);
        checkOutput("pre_rst_rvalid", {31'd0, bus.sb_rvalid}, 32'd1);
        checkOutput("pre_rst_bvalid", {31'd0, bus.sb_bvalid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rvalid", {31'd0, bus.sb_rvalid}, 32'd0);
        checkOutput("async_bvalid", {31'd0, bus.sb_bvalid}, 32'd0);
        rd_expect.delete();
        wr_expect.delete();
        model_reset();
        bus.sb_rready = 1'b1;
        bus.sb_bready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (SS + 1) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) do_read(32'(i * 4), 1);
        checkOutput("post_rst_irq", {31'd0, irq}, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rd_queue_drained", 32'(rd_expect.size()), 32'd0);
        checkOutput("wr_queue_drained", 32'(wr_expect.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
